regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 3-port register file.
// Merges single-cycle pipeline writebacks with buffered multi-cycle results
// and tracks in-flight multi-cycle destinations to stall hazardous issue.
module regfile_wb_arbiter #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pipe_we,
  input  logic [REG_IDX_WIDTH-1:0]         pipe_waddr,
  input  logic [WORD_LEN-1:0]              pipe_wdata,
  input  logic                             mc_valid,
  output logic                             mc_ready,
  input  logic [REG_IDX_WIDTH-1:0]         mc_waddr,
  input  logic [WORD_LEN-1:0]              mc_wdata,
  input  logic                             issue_mc,
  input  logic [REG_IDX_WIDTH-1:0]         issue_rd,
  input  logic [REG_IDX_WIDTH-1:0]         issue_rs1,
  input  logic [REG_IDX_WIDTH-1:0]         issue_rs2,
  output logic                             issue_stall,
  output logic                             rf_we,
  output logic [REG_IDX_WIDTH-1:0]         rf_waddr,
  output logic [WORD_LEN-1:0]              rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned REG_COUNT = 2 ** REG_IDX_WIDTH;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // Multi-cycle result buffer
  logic [REG_IDX_WIDTH-1:0] fifoAddr [FIFO_DEPTH];
  logic [WORD_LEN-1:0]      fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]         rdPtr;
  logic [PTR_W-1:0]         wrPtr;
  logic [CNT_W-1:0]         count;

  logic fifoEmpty;
  logic fifoFull;
  logic push;
  logic pop;
  logic pipeSel;
  logic [REG_IDX_WIDTH-1:0] headAddr;
  logic [WORD_LEN-1:0]      headData;

  // Registered write port plus a tag marking FIFO-sourced writes
  logic                     rfWe;
  logic [REG_IDX_WIDTH-1:0] rfWaddr;
  logic [WORD_LEN-1:0]      rfWdata;
  logic                     rfFromFifo;

  // Pending scoreboard
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pendingNext;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FULL_COUNT);
  assign mc_ready  = !fifoFull && !reset;
  assign push      = mc_valid && mc_ready;
  assign pipeSel   = pipe_we && (pipe_waddr != '0);
  // An empty FIFO never bypasses: only an entry already stored can pop.
  assign pop       = !pipeSel && !fifoEmpty;
  assign headAddr  = fifoAddr[rdPtr];
  assign headData  = fifoData[rdPtr];

  assign rf_we      = rfWe;
  assign rf_waddr   = rfWaddr;
  assign rf_wdata   = rfWdata;
  assign fifo_count = count;

  // FIFO storage: written on accepted multi-cycle results
  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr] <= mc_waddr;
      fifoData[wrPtr] <= mc_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write-port select: pipeline first, then FIFO head, else idle (address/data hold)
  always_ff @(posedge clk) begin
    if (reset) begin
      rfWe       <= 1'b0;
      rfWaddr    <= '0;
      rfWdata    <= '0;
      rfFromFifo <= 1'b0;
    end else if (pipeSel) begin
      rfWe       <= 1'b1;
      rfWaddr    <= pipe_waddr;
      rfWdata    <= pipe_wdata;
      rfFromFifo <= 1'b0;
    end else if (pop && (headAddr != '0)) begin
      rfWe       <= 1'b1;
      rfWaddr    <= headAddr;
      rfWdata    <= headData;
      rfFromFifo <= 1'b1;
    end else begin
      rfWe       <= 1'b0;
      rfFromFifo <= 1'b0;
    end
  end

  // Next scoreboard state: clear on FIFO-sourced write, then set (set wins)
  always_comb begin
    pendingNext = pending;
    if (rfWe && rfFromFifo) pendingNext[rfWaddr] = 1'b0;
    if (issue_mc && !issue_stall && (issue_rd != '0)) pendingNext[issue_rd] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pendingNext;
  end

  // Hazard stall from the current scoreboard only
  always_comb begin
    issue_stall = ((issue_rs1 != '0) && pending[issue_rs1]) ||
                  ((issue_rs2 != '0) && pending[issue_rs2]) ||
                  ((issue_rd  != '0) && pending[issue_rd]);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued when
// stimulus is issued and popped by a negedge monitor on every rf_we.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_waddr;
  logic [31:0] mc_wdata;
  logic        issue_mc;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_count;

  int nChecks = 0;
  int nFail   = 0;
  logic [36:0] expQ [$];

  regfile_wb_arbiter #(.WORD_LEN(32), .REG_IDX_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
    .issue_mc(issue_mc), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    expQ.push_back({a, d});
  endtask

  // Monitor: every presented write must match the head of the expected queue
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_write: got x%0d=0x%0h, expected no write at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        logic [36:0] e;
        e = expQ.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          nFail++;
          $display("FAIL write_order: got x%0d=0x%0h, expected x%0d=0x%0h at %0t",
                   rf_waddr, rf_wdata, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
    issue_mc = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;

    // Reset and idle
    cyc(); cyc();
    neg();
    check("ready_in_reset", 32'(mc_ready), 32'd0);
    cyc(); reset = 1'b0;
    cyc(); cyc(); cyc();
    neg();
    check("reset_rf_we",    32'(rf_we), 32'd0);
    check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_count",    32'(fifo_count), 32'd0);
    check("reset_ready",    32'(mc_ready), 32'd1);
    check("reset_stall",    32'(issue_stall), 32'd0);

    // Single pipeline write, one-cycle latency
    cyc(); pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
    expectWrite(5'd5, 32'hDEADBEEF);
    cyc(); pipe_we = 1'b0;
    neg(); check("pipe_lat_we", 32'(rf_we), 32'd1);
    cyc();
    neg(); check("pipe_after_we", 32'(rf_we), 32'd0);

    // Hazard reservation and release through a FIFO-sourced write
    cyc(); issue_mc = 1'b1; issue_rd = 5'd7;
    neg(); check("stall_issue_cycle", 32'(issue_stall), 32'd0);
    cyc(); issue_mc = 1'b0; issue_rd = '0; issue_rs1 = 5'd7;
    neg(); check("stall_raw", 32'(issue_stall), 32'd1);
    cyc(); mc_valid = 1'b1; mc_waddr = 5'd7; mc_wdata = 32'h12345678;
    expectWrite(5'd7, 32'h12345678);
    neg(); check("stall_push_cycle", 32'(issue_stall), 32'd1);
    cyc(); mc_valid = 1'b0;
    neg(); check("count_after_push", 32'(fifo_count), 32'd1);
    cyc();
    neg();
    check("mc_write_we", 32'(rf_we), 32'd1);
    check("stall_in_we_cycle", 32'(issue_stall), 32'd1);
    cyc();
    neg(); check("stall_cleared", 32'(issue_stall), 32'd0);
    issue_rs1 = '0;

    // Pipeline priority over two buffered entries
    cyc(); pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h900;
    mc_valid = 1'b1; mc_waddr = 5'd3; mc_wdata = 32'h3;
    expectWrite(5'd9, 32'h900);
    cyc(); pipe_wdata = 32'h901; mc_waddr = 5'd4; mc_wdata = 32'h4;
    expectWrite(5'd9, 32'h901);
    cyc(); pipe_wdata = 32'h902; mc_valid = 1'b0;
    expectWrite(5'd9, 32'h902);
    expectWrite(5'd3, 32'h3);
    expectWrite(5'd4, 32'h4);
    neg(); check("prio_count_c", 32'(fifo_count), 32'd2);
    cyc(); pipe_we = 1'b0;
    neg(); check("prio_count_d", 32'(fifo_count), 32'd2);
    cyc();
    neg(); check("prio_count_e", 32'(fifo_count), 32'd1);
    cyc();
    neg(); check("prio_count_f", 32'(fifo_count), 32'd0);

    // Fill to full under continuous pipeline writes, then hold a 5th entry
    for (int i = 0; i < 4; i++) begin
      cyc(); pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'hA0 + 32'(i);
      mc_valid = 1'b1; mc_waddr = 5'(11 + i); mc_wdata = 32'hB1 + 32'(i);
      expectWrite(5'd10, 32'hA0 + 32'(i));
    end
    cyc(); pipe_wdata = 32'hA4; mc_waddr = 5'd15; mc_wdata = 32'hB5;
    expectWrite(5'd10, 32'hA4);
    for (int i = 0; i < 5; i++) expectWrite(5'(11 + i), 32'hB1 + 32'(i));
    neg();
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(mc_ready), 32'd0);
    cyc(); pipe_we = 1'b0;
    neg();
    check("held_ready", 32'(mc_ready), 32'd0);
    check("held_count", 32'(fifo_count), 32'd4);
    cyc();
    neg();
    check("accept_ready", 32'(mc_ready), 32'd1);
    check("accept_count", 32'(fifo_count), 32'd3);
    cyc(); mc_valid = 1'b0;
    neg(); check("pushpop_count", 32'(fifo_count), 32'd3);
    cyc(); cyc(); cyc();
    neg(); check("drain_count", 32'(fifo_count), 32'd0);
    cyc();

    // Register x0 from both sources never reaches the write port
    cyc(); pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h77;
    mc_valid = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'h55;
    cyc(); mc_valid = 1'b0;
    neg(); check("x0_count_push", 32'(fifo_count), 32'd1);
    cyc(); pipe_we = 1'b0;
    neg();
    check("x0_count_pop", 32'(fifo_count), 32'd0);
    check("x0_no_we", 32'(rf_we), 32'd0);
    check("x0_addr_hold", 32'(rf_waddr), 32'd15);
    check("x0_data_hold", rf_wdata, 32'hB5);

    // Reset discards queued entries and pending bits
    cyc(); pipe_we = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'hC0;
    mc_valid = 1'b1; mc_waddr = 5'd21; mc_wdata = 32'hD1;
    issue_mc = 1'b1; issue_rd = 5'd21;
    expectWrite(5'd20, 32'hC0);
    cyc(); pipe_wdata = 32'hC1; mc_waddr = 5'd22; mc_wdata = 32'hD2; issue_rd = 5'd22;
    expectWrite(5'd20, 32'hC1);
    cyc(); pipe_wdata = 32'hC2; mc_waddr = 5'd23; mc_wdata = 32'hD3;
    issue_mc = 1'b0; issue_rd = '0; issue_rs1 = 5'd21;
    expectWrite(5'd20, 32'hC2);
    neg(); check("pre_reset_stall", 32'(issue_stall), 32'd1);
    cyc(); pipe_we = 1'b0; mc_valid = 1'b0; reset = 1'b1;
    neg();
    check("pre_reset_count", 32'(fifo_count), 32'd3);
    check("reset_mid_ready", 32'(mc_ready), 32'd0);
    cyc(); reset = 1'b0; issue_rs2 = 5'd22;
    neg();
    check("post_reset_count", 32'(fifo_count), 32'd0);
    check("post_reset_we", 32'(rf_we), 32'd0);
    check("post_reset_stall", 32'(issue_stall), 32'd0);
    cyc(); cyc(); cyc();
    neg();
    check("post_reset_idle_we", 32'(rf_we), 32'd0);
    check("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
